// File: rtl/serial_frame_tx.sv
// Frame transmitter: buffers signed samples in a FIFO and emits a header cycle plus
// len data cycles on an en/n/data interface, tracking the 9-bit wrapped sum to expect.
module serial_frame_tx #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_valid_i,
  input  logic [7:0]               wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     start_i,
  input  logic [7:0]               len_i,
  output logic                     err_o,
  output logic                     en_o,
  output logic [7:0]               n_o,
  output logic [7:0]               data_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [8:0]               exp_sum_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [7:0]      rem, rem_nxt;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level_nxt;
  logic [7:0]      head;
  logic            push, pop, pop_ahead, start_ok;

  assign head = mem[rd_ptr];
  assign push = wr_valid_i && wr_ready_o;
  assign pop  = (state == S_HDR) || ((state == S_DATA) && (rem != '0));

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    start_ok  = start_i && (len_i != '0) && (len_i <= 8'(level_o));
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt = S_HDR;
          rem_nxt   = len_i;
        end else if (!start_i) begin
          state_nxt = S_IDLE;
        end
      end
      S_HDR: begin
        state_nxt = S_DATA;
        rem_nxt   = rem - 8'd1;
      end
      S_DATA: begin
        if (rem != '0) rem_nxt = rem - 8'd1;
        else           state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // rem counts samples still to send after the one currently on data_o
  assign pop_ahead = (state_nxt == S_HDR) || ((state_nxt == S_DATA) && (rem_nxt != '0));

  always_comb begin
    level_nxt = level_o;
    if (push && !pop)      level_nxt = level_o + LW'(1);
    else if (!push && pop) level_nxt = level_o - LW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      rem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_o    <= '0;
      wr_ready_o <= 1'b1;
      err_o      <= 1'b0;
      en_o       <= 1'b0;
      n_o        <= '0;
      data_o     <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      exp_sum_o  <= '0;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      level_o <= level_nxt;
      // A full buffer still accepts a push when a pop is certain on the same edge,
      // so the level can hold steady while a frame streams out.
      wr_ready_o <= (level_nxt < FULL) || pop_ahead;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      err_o  <= start_i && !start_ok && ((state == S_IDLE) || (state == S_DONE));
      busy_o <= (state_nxt == S_HDR) || (state_nxt == S_DATA);
      en_o   <= (state_nxt != S_IDLE);
      done_o <= (state_nxt == S_DONE);
      n_o    <= (state_nxt == S_HDR) ? rem_nxt : '0;
      data_o <= pop ? head : '0;
      if (state_nxt == S_HDR) exp_sum_o <= '0;
      else if (pop)           exp_sum_o <= exp_sum_o + {head[7], head};
    end
  end

endmodule
